rect_draw_scheduler: RTL and testbench

//  Shares one rectangle-fill engine between N_REQ requesters (e.g. UI box drawer, cursor, screen clear).

---
 rtl/render_pkg.sv | 15 +
 rtl/rr_pick.sv | 32 +++
 rtl/rect_draw_scheduler.sv | 122 ++++++++++++
 tb/tb_rect_draw_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared rendering constants: FSM state encodings and default field widths
// used by the rectangle scheduler and the rectangle control FSMs.
package render_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int N_REQ_DEF  = 2;
   localparam int X_W_DEF    = 8;
   localparam int Y_W_DEF    = 7;
   localparam int SIZE_W_DEF = 4;
   localparam int COL_W_DEF  = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from
// i_ptr upward, wrapping modulo N_REQ.
module rr_pick
   import render_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_winner,
   output logic             o_valid
);

   logic [IDX_W-1:0] w_idx;

   // NOTE: every output gets a default before the loop, so no path leaves a value unassigned (no latch).
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_idx    = '0;
      // Scan from the farthest offset down so the closest set bit to i_ptr wins last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = IDX_W'((int'(i_ptr) + k) % N_REQ);
         if (i_req[w_idx]) begin
            o_winner = w_idx;
            o_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rect_draw_scheduler.sv
// Shares one rectangle-fill engine between N_REQ requesters: round-robin
// arbitration, command latching and a row-major pixel scan to the VGA plot port.
module rect_draw_scheduler
   import render_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int X_W    = X_W_DEF,
   parameter int Y_W    = Y_W_DEF,
   parameter int SIZE_W = SIZE_W_DEF,
   parameter int COL_W  = COL_W_DEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*X_W-1:0]    req_x,
   input  logic [N_REQ*Y_W-1:0]    req_y,
   input  logic [N_REQ*SIZE_W-1:0] req_w,
   input  logic [N_REQ*SIZE_W-1:0] req_h,
   input  logic [N_REQ*COL_W-1:0]  req_colour,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        done,
   output logic                    busy,
   output logic                    plot,
   output logic [X_W-1:0]          x_out,
   output logic [Y_W-1:0]          y_out,
   output logic [COL_W-1:0]        colour_out
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [1:0]        r_state;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  r_owner;
   logic [X_W-1:0]    r_x0;
   logic [Y_W-1:0]    r_y0;
   logic [SIZE_W-1:0] r_w;
   logic [SIZE_W-1:0] r_h;
   logic [COL_W-1:0]  r_col;
   logic [SIZE_W-1:0] r_cx;
   logic [SIZE_W-1:0] r_cy;
   logic [N_REQ-1:0]  r_grant;

   logic [IDX_W-1:0]  w_winner;
   logic              w_valid;
   logic              w_zero;
   logic              w_row_end;
   logic              w_last;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   assign w_zero    = (r_w == '0) || (r_h == '0);
   assign w_row_end = (r_cx == r_w - SIZE_W'(1));
   assign w_last    = w_row_end && (r_cy == r_h - SIZE_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_w     <= '0;
         r_h     <= '0;
         r_col   <= '0;
         r_cx    <= '0;
         r_cy    <= '0;
         r_grant <= '0;
      end else begin
         r_grant <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_state <= S_DRAW;
                  r_owner <= w_winner;
                  r_x0    <= req_x[w_winner*X_W +: X_W];
                  r_y0    <= req_y[w_winner*Y_W +: Y_W];
                  r_w     <= req_w[w_winner*SIZE_W +: SIZE_W];
                  r_h     <= req_h[w_winner*SIZE_W +: SIZE_W];
                  r_col   <= req_colour[w_winner*COL_W +: COL_W];
                  r_cx    <= '0;
                  r_cy    <= '0;
                  r_grant <= N_REQ'(1) << w_winner;
               end
            end
            S_DRAW: begin
               // cx/cy are left on the final pixel so x_out/y_out hold it afterwards.
               if (w_zero || w_last) begin
                  r_state <= S_DONE;
               end else if (w_row_end) begin
                  r_cx <= '0;
                  r_cy <= r_cy + SIZE_W'(1);
               end else begin
                  r_cx <= r_cx + SIZE_W'(1);
               end
            end
            S_DONE: begin
               r_ptr   <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign grant      = r_grant;
   assign done       = (r_state == S_DONE) ? (N_REQ'(1) << r_owner) : '0;
   assign busy       = (r_state != S_IDLE);
   assign plot       = (r_state == S_DRAW) && !w_zero;
   assign x_out      = r_x0 + X_W'(r_cx);
   assign y_out      = r_y0 + Y_W'(r_cy);
   assign colour_out = r_col;

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Self-checking bench for rect_draw_scheduler: directed scenarios plus random
// request mixes, all checked against a command-level model of the scheduler.
module tb_rect_draw_scheduler;
   import render_pkg::*;

   localparam int N  = N_REQ_DEF;
   localparam int XW = X_W_DEF;
   localparam int YW = Y_W_DEF;
   localparam int SW = SIZE_W_DEF;
   localparam int CW = COL_W_DEF;

   logic              clk = 1'b0;
   logic              resetn;
   logic [N-1:0]      req;
   logic [N*XW-1:0]   req_x;
   logic [N*YW-1:0]   req_y;
   logic [N*SW-1:0]   req_w;
   logic [N*SW-1:0]   req_h;
   logic [N*CW-1:0]   req_colour;
   logic [N-1:0]      grant;
   logic [N-1:0]      done;
   logic              busy;
   logic              plot;
   logic [XW-1:0]     x_out;
   logic [YW-1:0]     y_out;
   logic [CW-1:0]     colour_out;

   rect_draw_scheduler dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_w      (req_w),
      .req_h      (req_h),
      .req_colour (req_colour),
      .grant      (grant),
      .done       (done),
      .busy       (busy),
      .plot       (plot),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour_out (colour_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests  = 0;
   int failed = 0;
   int cmd_x[N], cmd_y[N], cmd_w[N], cmd_h[N], cmd_c[N];
   int m_ptr;
   int last_grant_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int i, input int x, input int y, input int w, input int h, input int c);
      cmd_x[i] = x; cmd_y[i] = y; cmd_w[i] = w; cmd_h[i] = h; cmd_c[i] = c;
      req_x[i*XW +: XW]      = XW'(x);
      req_y[i*YW +: YW]      = YW'(y);
      req_w[i*SW +: SW]      = SW'(w);
      req_h[i*SW +: SW]      = SW'(h);
      req_colour[i*CW +: CW] = CW'(c);
   endtask

   task automatic rand_cmd(input int i);
      set_cmd(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
   endtask

   // Command-level arbitration rule: first pending requester at or after the pointer.
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // Called at a negedge while the DUT is idle; follows one whole command to its idle gap.
   task automatic expect_next(input bit rel, output int lat);
      int who;
      int n;
      who = pick(req, m_ptr);
      @(negedge clk);
      n = 1;
      while (grant === '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      check("grant", 32'(grant), 32'd1 << who);
      last_grant_cyc = cyc;
      if (rel) req[who] = 1'b0;
      if (cmd_w[who] == 0 || cmd_h[who] == 0) begin
         check("zero_plot", 32'(plot), 32'd0);
         @(negedge clk);
      end else begin
         for (int r = 0; r < cmd_h[who]; r++) begin
            for (int c = 0; c < cmd_w[who]; c++) begin
               check("plot", 32'(plot), 32'd1);
               check("x_out", 32'(x_out), 32'((cmd_x[who] + c) % (1 << XW)));
               check("y_out", 32'(y_out), 32'((cmd_y[who] + r) % (1 << YW)));
               check("colour", 32'(colour_out), 32'(cmd_c[who]));
               @(negedge clk);
            end
         end
      end
      check("done", 32'(done), 32'd1 << who);
      check("done_grant", 32'(grant), 32'd0);
      check("done_plot", 32'(plot), 32'd0);
      m_ptr = (who + 1) % N;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      m_ptr  = 0;
   endtask

   initial begin
      int lat;
      int g0;
      int n;
      resetn = 1'b0;
      req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
      for (int i = 0; i < N; i++) set_cmd(i, 0, 0, 0, 0, 0);
      m_ptr = 0;
      last_grant_cyc = 0;

      // Reset state
      #23;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_plot", 32'(plot), 32'd0);
      check("rst_x", 32'(x_out), 32'd0);
      check("rst_y", 32'(y_out), 32'd0);
      check("rst_col", 32'(colour_out), 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Single 2x2 rectangle
      set_cmd(0, 10, 20, 2, 2, 5);
      req[0] = 1'b1;
      expect_next(1'b1, lat);
      check("t1_latency", 32'(lat), 32'd1);

      // Contention from reset: 0, 1, 0
      do_reset();
      for (int i = 0; i < N; i++) rand_cmd(i);
      req = '1;
      for (int k = 0; k < 3; k++) expect_next(1'b0, lat);
      req = '0;

      // X wrap
      set_cmd(0, 254, int'($urandom_range(0, 127)), 4, 1, int'($urandom_range(0, 7)));
      req[0] = 1'b1;
      expect_next(1'b1, lat);

      // Zero-size commands
      set_cmd(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 0, 3, int'($urandom_range(0, 7)));
      req[1] = 1'b1;
      expect_next(1'b1, lat);
      set_cmd(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 3, 0, int'($urandom_range(0, 7)));
      req[0] = 1'b1;
      expect_next(1'b1, lat);

      // Reset during pixel 3 of a 4x4 rectangle
      set_cmd(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 4, 4, int'($urandom_range(0, 7)));
      set_cmd(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(0, 7)));
      req = '1;
      @(negedge clk);
      n = 1;
      while (grant === '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t5_grant", 32'(grant), 32'd1 << pick(req, m_ptr));
      @(negedge clk);
      @(negedge clk);
      check("t5_pix3_x", 32'(x_out), 32'((cmd_x[1] + 2) % (1 << XW)));
      #2 resetn = 1'b0;
      #1;
      check("t5_async_plot", 32'(plot), 32'd0);
      check("t5_async_busy", 32'(busy), 32'd0);
      check("t5_async_grant", 32'(grant), 32'd0);
      check("t5_async_done", 32'(done), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t5_no_done", 32'(done), 32'd0);
      end
      resetn = 1'b1;
      m_ptr  = 0;
      expect_next(1'b1, lat);
      expect_next(1'b1, lat);

      // Back-to-back single pixels
      set_cmd(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1, 1, int'($urandom_range(0, 7)));
      req[1] = 1'b1;
      expect_next(1'b0, lat);
      for (int k = 0; k < 2; k++) begin
         g0 = last_grant_cyc;
         expect_next(1'b0, lat);
         check("t6_spacing", 32'(last_grant_cyc - g0), 32'd3);
      end
      req = '0;

      // Random request mixes
      for (int it = 0; it < 16; it++) begin
         for (int i = 0; i < N; i++) rand_cmd(i);
         req = N'($urandom_range(1, (1 << N) - 1));
         while (req != '0) expect_next(1'b1, lat);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
